// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } kind_e;

    // Data wins over fetch: the data access belongs to the older instruction.
    localparam bit PRIO_DATA = 1'b1;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter; last_cycle flags the terminal count of a multi-cycle operation.
module arb_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         last_cycle
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign last_cycle = (cnt_q == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and load/store,
// returning per-port ack/rdata and pipeline stall signals.
//
//  state | meaning
//  ------+--------------------------------------------------
//  IDLE  | no access in flight, any request may be granted
//  ACC_I | fetch access in progress
//  ACC_D | load/store access in progress
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              proto_err,
    output logic [CNT_W-1:0]  if_stall_cnt,
    output logic [CNT_W-1:0]  dm_stall_cnt
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_hold_q, if_hold_d;
    logic [DATA_W-1:0] dm_hold_q, dm_hold_d;
    logic              proto_err_q, proto_err_d;
    logic [CNT_W-1:0]  if_stall_cnt_q, if_stall_cnt_d;
    logic [CNT_W-1:0]  dm_stall_cnt_q, dm_stall_cnt_d;

    logic              acc_last;
    logic              arb_point;
    logic              d_elig;
    logic              i_elig;
    logic              grant_d;
    logic              grant_i;
    logic              lat_last;
    logic [LAT_W-1:0]  lat_cnt;

    arb_lat_counter #(
        .W (LAT_W)
    ) u_lat (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_d || grant_i),
        .load_val   (LAT_W'(MEM_LAT)),
        .dec        (state_q != IDLE),
        .cnt        (lat_cnt),
        .last_cycle (lat_last)
    );

    always_comb begin
        acc_last  = (state_q != IDLE) && lat_last;
        arb_point = (state_q == IDLE) || acc_last;
        // The port being acked this cycle still shows its old request; skip it.
        d_elig    = (dm_read || dm_write) && !((state_q == ACC_D) && acc_last);
        i_elig    = if_req && !((state_q == ACC_I) && acc_last);
        grant_d   = arb_point && d_elig && (PRIO_DATA || !i_elig);
        grant_i   = arb_point && i_elig && !grant_d;

        // Acks are suppressed while rst is high so an aborted access never completes.
        if_ack    = !rst && (state_q == ACC_I) && acc_last;
        dm_ack    = !rst && (state_q == ACC_D) && acc_last;
        if_stall  = if_req && !if_ack;
        dm_stall  = (dm_read || dm_write) && !dm_ack;

        state_d = state_q;
        if (grant_d) begin
            state_d = ACC_D;
        end else if (grant_i) begin
            state_d = ACC_I;
        end else if (acc_last) begin
            state_d = IDLE;
        end

        addr_d      = addr_q;
        wdata_d     = wdata_q;
        kind_d      = kind_q;
        proto_err_d = proto_err_q;
        if (grant_d) begin
            addr_d      = dm_addr;
            wdata_d     = dm_wdata;
            kind_d      = dm_write ? WR : RD;
            proto_err_d = proto_err_q || (dm_read && dm_write);
        end else if (grant_i) begin
            addr_d = if_addr;
            kind_d = RD;
        end

        if_hold_d = if_hold_q;
        if_rdata  = if_hold_q;
        if (if_ack) begin
            if_hold_d = mem_rdata;
            if_rdata  = mem_rdata;
        end

        dm_hold_d = dm_hold_q;
        dm_rdata  = dm_hold_q;
        if (dm_ack && (kind_q == RD)) begin
            dm_hold_d = mem_rdata;
            dm_rdata  = mem_rdata;
        end

        if_stall_cnt_d = if_stall_cnt_q;
        if (if_stall && (if_stall_cnt_q != '1)) begin
            if_stall_cnt_d = if_stall_cnt_q + CNT_W'(1);
        end
        dm_stall_cnt_d = dm_stall_cnt_q;
        if (dm_stall && (dm_stall_cnt_q != '1)) begin
            dm_stall_cnt_d = dm_stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            kind_q         <= RD;
            addr_q         <= '0;
            wdata_q        <= '0;
            if_hold_q      <= '0;
            dm_hold_q      <= '0;
            proto_err_q    <= 1'b0;
            if_stall_cnt_q <= '0;
            dm_stall_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            if_hold_q      <= if_hold_d;
            dm_hold_q      <= dm_hold_d;
            proto_err_q    <= proto_err_d;
            if_stall_cnt_q <= if_stall_cnt_d;
            dm_stall_cnt_q <= dm_stall_cnt_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign mem_read     = busy && (kind_q == RD);
    assign mem_write    = busy && (kind_q == WR);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign proto_err    = proto_err_q;
    assign if_stall_cnt = if_stall_cnt_q;
    assign dm_stall_cnt = dm_stall_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: MEM_LAT=2 main instance plus a MEM_LAT=1, CNT_W=4 instance on shared inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;

    logic        if_ack, if_stall, dm_ack, dm_stall, mem_read, mem_write, busy, proto_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [15:0] if_stall_cnt, dm_stall_cnt;

    logic        if_ack_1, if_stall_1, dm_ack_1, dm_stall_1, mem_read_1, mem_write_1, busy_1, proto_err_1;
    logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1;
    logic [3:0]  if_stall_cnt_1, dm_stall_cnt_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err),
        .if_stall_cnt(if_stall_cnt), .dm_stall_cnt(dm_stall_cnt)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_1), .if_rdata(if_rdata_1), .if_stall(if_stall_1),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack_1), .dm_rdata(dm_rdata_1), .dm_stall(dm_stall_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_read(mem_read_1), .mem_write(mem_write_1),
        .mem_rdata(mem_rdata), .busy(busy_1), .proto_err(proto_err_1),
        .if_stall_cnt(if_stall_cnt_1), .dm_stall_cnt(dm_stall_cnt_1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if ({if_ack, dm_ack, mem_read, mem_write, proto_err} !== 5'b0) begin
            errors++; $display("FAIL rst_flags: got %b exp 00000", {if_ack, dm_ack, mem_read, mem_write, proto_err}); end
        checks++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            errors++; $display("FAIL rst_data: got %h exp 0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
        checks++; if ({if_stall_cnt, dm_stall_cnt} !== 32'h0) begin
            errors++; $display("FAIL rst_cnt: got %h exp 0", {if_stall_cnt, dm_stall_cnt}); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        do_reset();
        step();
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h8C22_0004;
        #1;
        checks++; if ({busy, if_ack, if_stall} !== 3'b001) begin
            errors++; $display("FAIL fetch_t0: got %b exp 001", {busy, if_ack, if_stall}); end
        step();
        checks++; if ({mem_read, mem_write, if_ack} !== 3'b100 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL fetch_t1: got %b addr %h exp 100 addr 10", {mem_read, mem_write, if_ack}, mem_addr); end
        step();
        #1;
        checks++; if ({mem_read, if_ack, if_stall} !== 3'b110 || if_rdata !== 32'h8C22_0004) begin
            errors++; $display("FAIL fetch_t2: got %b rdata %h exp 110 rdata 8c220004", {mem_read, if_ack, if_stall}, if_rdata); end
        step();
        if_req = 1'b0; mem_rdata = 32'h1111_1111;
        #1;
        checks++; if ({busy, mem_read, if_ack} !== 3'b000 || if_rdata !== 32'h8C22_0004) begin
            errors++; $display("FAIL fetch_hold: got %b rdata %h exp 000 rdata 8c220004", {busy, mem_read, if_ack}, if_rdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        if_req = 1'b1; if_addr = 32'h20; dm_read = 1'b1; dm_addr = 32'h40; mem_rdata = 32'hA5A5_0001;
        step();
        checks++; if (mem_addr !== 32'h40 || {mem_read, dm_ack, if_stall, dm_stall} !== 4'b1011) begin
            errors++; $display("FAIL b2b_t1: got addr %h flags %b exp addr 40 flags 1011", mem_addr, {mem_read, dm_ack, if_stall, dm_stall}); end
        step();
        checks++; if ({dm_ack, if_ack, dm_stall, if_stall} !== 4'b1001 || dm_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL b2b_t2: got %b rdata %h exp 1001 rdata a5a50001", {dm_ack, if_ack, dm_stall, if_stall}, dm_rdata); end
        step();
        dm_read = 1'b0; mem_rdata = 32'h0BAD_F00D;
        #1;
        checks++; if (busy !== 1'b1 || mem_addr !== 32'h20 || dm_ack !== 1'b0 || dm_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL b2b_t3: got busy %b addr %h ack %b rdata %h exp 1 20 0 a5a50001", busy, mem_addr, dm_ack, dm_rdata); end
        step();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL b2b_t4: got ack %b rdata %h exp 1 0badf00d", if_ack, if_rdata); end
        step();
        if_req = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", busy); end
    endtask

    task automatic test_write();
        step();
        dm_write = 1'b1; dm_addr = 32'h44; dm_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
        step();
        checks++; if ({mem_write, mem_read, dm_ack} !== 3'b100 || mem_addr !== 32'h44 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_t1: got %b addr %h data %h exp 100 44 deadbeef", {mem_write, mem_read, dm_ack}, mem_addr, mem_wdata); end
        step();
        checks++; if ({mem_write, dm_ack} !== 2'b11 || mem_wdata !== 32'hDEAD_BEEF || dm_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL wr_t2: got %b data %h rdata %h exp 11 deadbeef a5a50001", {mem_write, dm_ack}, mem_wdata, dm_rdata); end
        step();
        dm_write = 1'b0;
        #1;
        checks++; if ({busy, mem_write, dm_ack} !== 3'b000 || dm_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL wr_t3: got %b rdata %h exp 000 a5a50001", {busy, mem_write, dm_ack}, dm_rdata); end
    endtask

    task automatic test_alternate();
        logic exp_d;
        logic exp_i;
        logic [31:0] exp_addr;
        do_reset();
        step();
        if_req = 1'b1; if_addr = 32'h30; dm_read = 1'b1; dm_addr = 32'h80; mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            #1;
            exp_d = (k == 2) || (k == 6);
            exp_i = (k == 4) || (k == 8);
            checks++; if (dm_ack !== exp_d || if_ack !== exp_i) begin
                errors++; $display("FAIL alt_ack[%0d]: got d%b i%b exp d%b i%b", k, dm_ack, if_ack, exp_d, exp_i); end
            if (k > 0) begin
                exp_addr = ((k - 1) % 4 < 2) ? 32'h80 : 32'h30;
                checks++; if (mem_addr !== exp_addr || busy !== 1'b1) begin
                    errors++; $display("FAIL alt_addr[%0d]: got %h busy %b exp %h busy 1", k, mem_addr, busy, exp_addr); end
            end
        end
        step();
        if_req = 1'b0; dm_read = 1'b0;
        #1;
        checks++; if (if_stall_cnt !== 16'd7 || dm_stall_cnt !== 16'd7) begin
            errors++; $display("FAIL alt_cnt: got if %0d dm %0d exp 7 7", if_stall_cnt, dm_stall_cnt); end
        checks++; if (mem_addr !== 32'h80 || busy !== 1'b1) begin
            errors++; $display("FAIL alt_regrant: got %h busy %b exp 80 busy 1", mem_addr, busy); end
        step();
        checks++; if (dm_ack !== 1'b1 || dm_stall !== 1'b0 || dm_stall_cnt !== 16'd7) begin
            errors++; $display("FAIL drop_ack: got ack %b stall %b cnt %0d exp 1 0 7", dm_ack, dm_stall, dm_stall_cnt); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        dm_read = 1'b1; dm_addr = 32'h48; mem_rdata = 32'h7777_7777;
        step();
        rst = 1'b1;
        #1;
        checks++; if ({busy, mem_read, dm_ack} !== 3'b110) begin
            errors++; $display("FAIL rmid_t1: got %b exp 110", {busy, mem_read, dm_ack}); end
        checks++; if (dm_ack_1 !== 1'b0) begin errors++; $display("FAIL rmid_lat1_ack: got %b exp 0", dm_ack_1); end
        step();
        dm_read = 1'b0;
        #1;
        checks++; if ({busy, mem_read, mem_write, dm_ack, if_ack} !== 5'b0 || mem_addr !== 32'h0 || dm_rdata !== 32'h0) begin
            errors++; $display("FAIL rmid_t2: got %b addr %h rdata %h exp 00000 0 0", {busy, mem_read, mem_write, dm_ack, if_ack}, mem_addr, dm_rdata); end
        checks++; if (busy_1 !== 1'b0 || dm_rdata_1 !== 32'h0) begin
            errors++; $display("FAIL rmid_lat1_t2: got busy %b rdata %h exp 0 0", busy_1, dm_rdata_1); end
        rst = 1'b0;
    endtask

    task automatic test_proto_err();
        do_reset();
        step();
        dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h50; dm_wdata = 32'hCAFE_F00D; mem_rdata = 32'h9999_0000;
        step();
        checks++; if ({mem_write, mem_read, proto_err} !== 3'b101 || mem_wdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL proto_t1: got %b data %h exp 101 cafef00d", {mem_write, mem_read, proto_err}, mem_wdata); end
        step();
        checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h0) begin
            errors++; $display("FAIL proto_t2: got ack %b rdata %h exp 1 0", dm_ack, dm_rdata); end
        step();
        dm_read = 1'b0; dm_write = 1'b0;
        step();
        step();
        checks++; if (proto_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL proto_sticky: got %b busy %b exp 1 0", proto_err, busy); end
        do_reset();
        #1;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr: got %b exp 0", proto_err); end
    endtask

    task automatic test_lat1();
        do_reset();
        step();
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h8C22_0004;
        step();
        checks++; if ({if_ack_1, mem_read_1} !== 2'b11 || if_rdata_1 !== 32'h8C22_0004 || mem_addr_1 !== 32'h10) begin
            errors++; $display("FAIL lat1_t1: got %b rdata %h addr %h exp 11 8c220004 10", {if_ack_1, mem_read_1}, if_rdata_1, mem_addr_1); end
        checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL lat2_not_yet: got %b exp 0", if_ack); end
        step();
        checks++; if ({if_ack_1, busy_1, if_stall_1} !== 3'b001) begin
            errors++; $display("FAIL lat1_t2: got %b exp 001", {if_ack_1, busy_1, if_stall_1}); end
        for (int k = 0; k < 38; k++) step();
        checks++; if (if_stall_cnt_1 !== 4'hF) begin
            errors++; $display("FAIL lat1_sat: got %h exp f", if_stall_cnt_1); end
        if_req = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_back_to_back();
        test_write();
        test_alternate();
        test_reset_mid();
        test_proto_err();
        test_lat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
